// File: rtl/calc_pkg.sv
// Address-width helpers and the rectangle clipping function for the command decoders.
package calc_pkg;

  typedef enum logic [2:0] {X1, Y1, W, H, COLOR} fillarea_arg_e;

  // Wide enough to hold a full-panel extent, not just the last index.
  function automatic int unsigned num_column_address_bits(input int unsigned cols);
    return $clog2(cols + 1);
  endfunction

  function automatic int unsigned num_row_address_bits(input int unsigned rows);
    return $clog2(rows + 1);
  endfunction

  // Length of [start, start+len) that lies inside [0, max); zero when start is off-panel.
  function automatic logic [8:0] clip_extent(input logic [8:0] start,
                                             input logic [8:0] len,
                                             input logic [8:0] max);
    logic [8:0] room;
    room = 9'd0;
    if (start >= max) return 9'd0;
    room = max - start;
    return (len < room) ? len : room;
  endfunction

endpackage

// File: rtl/params_pkg.sv
// Panel geometry and pixel format shared by the display command front ends.
package params_pkg;

  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned PIXEL_WIDTH     = 64;
  localparam int unsigned PIXEL_HEIGHT    = 32;

endpackage

// File: rtl/control_cmd_fillarea.sv
// Fill-area command front end: gathers the argument bytes, clips the rectangle to the
// panel, drives the fill sub-command handshake and reports completion upstream.
module control_cmd_fillarea
  import calc_pkg::*;
#(
  parameter int unsigned BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
  parameter int unsigned PIXEL_WIDTH     = params_pkg::PIXEL_WIDTH,
  parameter int unsigned PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT,
  parameter int unsigned _UNUSED         = 0,
  localparam int unsigned CW  = num_column_address_bits(PIXEL_WIDTH),
  localparam int unsigned RW  = num_row_address_bits(PIXEL_HEIGHT),
  localparam int unsigned CLW = BYTES_PER_PIXEL * 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [7:0]     data_in,
  input  logic           data_ready,
  input  logic           ack,
  output logic           done,
  output logic [CW-1:0]  x1,
  output logic [RW-1:0]  y1,
  output logic [CW-1:0]  width,
  output logic [RW-1:0]  height,
  output logic [CLW-1:0] color,
  output logic           subcmd_enable,
  input  logic           subcmd_done,
  output logic           subcmd_ack
);

  typedef enum logic [3:0] {
    S_IDLE, S_X1, S_Y1, S_W, S_H, S_COLOR, S_CLIP, S_FILL, S_SUBACK, S_DONE
  } state_e;

  localparam int unsigned    CNTW      = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam logic [CNTW-1:0] LAST_BYTE = CNTW'(BYTES_PER_PIXEL - 1);

  // Reserved parameter; no behaviour attached.
  if (_UNUSED != 0) begin : g_unused
  end

  state_e         state, state_d;
  logic [CW-1:0]  x1_arg, x1_arg_d;
  logic [RW-1:0]  y1_arg, y1_arg_d;
  logic [7:0]     w_arg, w_arg_d;
  logic [7:0]     h_arg, h_arg_d;
  logic [CLW-1:0] color_arg, color_arg_d;
  logic [CNTW-1:0] cnt, cnt_d;
  logic [CW-1:0]  x1_d, width_d;
  logic [RW-1:0]  y1_d, height_d;
  logic [CLW-1:0] color_d;
  logic           done_d, subcmd_enable_d, subcmd_ack_d;
  logic [8:0]     clip_w, clip_h;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state, argument capture and output values; outputs are decoded from the next state.
  always_comb begin
    state_d     = state;
    x1_arg_d    = x1_arg;
    y1_arg_d    = y1_arg;
    w_arg_d     = w_arg;
    h_arg_d     = h_arg;
    color_arg_d = color_arg;
    cnt_d       = cnt;
    x1_d        = x1;
    y1_d        = y1;
    width_d     = width;
    height_d    = height;
    color_d     = color;
    clip_w      = clip_extent(9'(x1_arg), 9'(w_arg), 9'(PIXEL_WIDTH));
    clip_h      = clip_extent(9'(y1_arg), 9'(h_arg), 9'(PIXEL_HEIGHT));

    case (state)
      S_IDLE: if (enable) state_d = S_X1;
      S_X1: begin
        if (!enable) state_d = S_IDLE;
        else if (data_ready) begin
          x1_arg_d = CW'(data_in);
          state_d  = S_Y1;
        end
      end
      S_Y1: begin
        if (!enable) state_d = S_IDLE;
        else if (data_ready) begin
          y1_arg_d = RW'(data_in);
          state_d  = S_W;
        end
      end
      S_W: begin
        if (!enable) state_d = S_IDLE;
        else if (data_ready) begin
          w_arg_d = data_in;
          state_d = S_H;
        end
      end
      S_H: begin
        if (!enable) state_d = S_IDLE;
        else if (data_ready) begin
          h_arg_d = data_in;
          cnt_d   = '0;
          state_d = S_COLOR;
        end
      end
      S_COLOR: begin
        if (!enable) state_d = S_IDLE;
        else if (data_ready) begin
          color_arg_d = (color_arg << 8) | CLW'(data_in);
          if (cnt == LAST_BYTE) state_d = S_CLIP;
          else                  cnt_d   = cnt + CNTW'(1);
        end
      end
      S_CLIP: begin
        x1_d     = x1_arg;
        y1_d     = y1_arg;
        width_d  = CW'(clip_w);
        height_d = RW'(clip_h);
        color_d  = color_arg;
        // An empty rectangle never launches the fill.
        state_d  = (clip_w == 9'd0 || clip_h == 9'd0) ? S_DONE : S_FILL;
      end
      S_FILL:   if (subcmd_done) state_d = S_SUBACK;
      S_SUBACK: state_d = S_DONE;
      S_DONE:   if (ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    done_d          = (state_d == S_DONE);
    subcmd_enable_d = (state_d == S_FILL);
    subcmd_ack_d    = (state_d == S_SUBACK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x1_arg        <= '0;
      y1_arg        <= '0;
      w_arg         <= '0;
      h_arg         <= '0;
      color_arg     <= '0;
      cnt           <= '0;
      x1            <= '0;
      y1            <= '0;
      width         <= '0;
      height        <= '0;
      color         <= '0;
      done          <= 1'b0;
      subcmd_enable <= 1'b0;
      subcmd_ack    <= 1'b0;
    end else begin
      x1_arg        <= x1_arg_d;
      y1_arg        <= y1_arg_d;
      w_arg         <= w_arg_d;
      h_arg         <= h_arg_d;
      color_arg     <= color_arg_d;
      cnt           <= cnt_d;
      x1            <= x1_d;
      y1            <= y1_d;
      width         <= width_d;
      height        <= height_d;
      color         <= color_d;
      done          <= done_d;
      subcmd_enable <= subcmd_enable_d;
      subcmd_ack    <= subcmd_ack_d;
    end
  end

endmodule

// File: tb/tb_control_cmd_fillarea.sv
// Directed bench for control_cmd_fillarea with a clipping model and an expected-result queue.
module tb_control_cmd_fillarea;

  localparam int BPP = params_pkg::BYTES_PER_PIXEL;
  localparam int PW  = params_pkg::PIXEL_WIDTH;
  localparam int PH  = params_pkg::PIXEL_HEIGHT;
  localparam int CW  = calc_pkg::num_column_address_bits(PW);
  localparam int RW  = calc_pkg::num_row_address_bits(PH);
  localparam int CLW = BPP * 8;

  typedef struct packed {
    logic           empty;
    logic [CW-1:0]  x1;
    logic [RW-1:0]  y1;
    logic [CW-1:0]  w;
    logic [RW-1:0]  h;
    logic [CLW-1:0] color;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset, enable, data_ready, ack, subcmd_done;
  logic [7:0]     data_in;
  logic           done, subcmd_enable, subcmd_ack;
  logic [CW-1:0]  x1, width;
  logic [RW-1:0]  y1, height;
  logic [CLW-1:0] color;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  control_cmd_fillarea dut (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
    .data_ready(data_ready), .ack(ack), .done(done), .x1(x1), .y1(y1),
    .width(width), .height(height), .color(color),
    .subcmd_enable(subcmd_enable), .subcmd_done(subcmd_done), .subcmd_ack(subcmd_ack)
  );

  function automatic exp_t model(input logic [7:0] xa, input logic [7:0] ya,
                                 input logic [7:0] wa, input logic [7:0] ha,
                                 input logic [CLW-1:0] col);
    exp_t m;
    int xv, yv, wv, hv;
    xv = int'(xa) % (1 << CW);
    yv = int'(ya) % (1 << RW);
    wv = int'(wa);
    hv = int'(ha);
    m.empty = (xv >= PW) || (yv >= PH) || (wv == 0) || (hv == 0);
    if (xv < PW && wv > PW - xv) wv = PW - xv;
    if (yv < PH && hv > PH - yv) hv = PH - yv;
    m.x1 = CW'(xv);
    m.y1 = RW'(yv);
    m.w = CW'(wv);
    m.h = RW'(hv);
    m.color = col;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      data_ready = 1'b0;
      data_in = 8'($urandom);
      step();
    end
    data_ready = 1'b1;
    data_in = b;
    step();
  endtask

  task automatic check_args(input string name, input exp_t e);
    check({name, "/x1"}, 32'(x1), 32'(e.x1));
    check({name, "/y1"}, 32'(y1), 32'(e.y1));
    check({name, "/width"}, 32'(width), 32'(e.w));
    check({name, "/height"}, 32'(height), 32'(e.h));
    check({name, "/color"}, 32'(color), 32'(e.color));
  endtask

  // One whole command from the enable rise through the upstream ack.
  task automatic run_cmd(input string name, input logic [7:0] xa, input logic [7:0] ya,
                         input logic [7:0] wa, input logic [7:0] ha,
                         input logic [CLW-1:0] col, input int gap);
    exp_t e;
    logic [1:0] path;
    enable = 1'b1;
    data_ready = 1'b1;
    data_in = 8'hA5;
    step();
    send(xa, gap);
    send(ya, gap);
    send(wa, gap);
    send(ha, gap);
    sb.push_back(model(xa, ya, wa, ha, col));
    for (int k = BPP - 1; k >= 0; k--) send(col[k*8 +: 8], gap);
    data_ready = 1'b0;
    check({name, "/early"}, 32'({done, subcmd_enable, subcmd_ack}), 32'd0);
    step();
    path = done ? 2'd1 : (subcmd_enable ? 2'd2 : 2'd0);
    e = sb.pop_front();
    check({name, "/path"}, 32'(path), e.empty ? 32'd1 : 32'd2);
    if (!e.empty) begin
      check_args(name, e);
      for (int i = 0; i < 3; i++) begin
        ack = (i == 0);
        step();
        check({name, "/fill_hold"}, 32'({subcmd_enable, subcmd_ack, done}), 32'b100);
      end
      ack = 1'b0;
      subcmd_done = 1'b1;
      step();
      check({name, "/suback"}, 32'({subcmd_enable, subcmd_ack, done}), 32'b010);
      subcmd_done = 1'b0;
      step();
      check({name, "/done_rise"}, 32'({subcmd_enable, subcmd_ack, done}), 32'b001);
      check_args({name, "_stable"}, e);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      check({name, "/done_hold"}, 32'({subcmd_enable, subcmd_ack, done}), 32'b001);
    end
    ack = 1'b1;
    step();
    check({name, "/acked"}, 32'({subcmd_enable, subcmd_ack, done}), 32'b000);
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [CLW-1:0] col;
    reset = 1'b1;
    enable = 1'b0;
    data_ready = 1'b0;
    data_in = 8'h00;
    ack = 1'b0;
    subcmd_done = 1'b0;
    repeat (3) step();
    check("reset/flags", 32'({done, subcmd_enable, subcmd_ack}), 32'd0);
    check("reset/x1", 32'(x1), 32'd0);
    check("reset/y1", 32'(y1), 32'd0);
    check("reset/width", 32'(width), 32'd0);
    check("reset/height", 32'(height), 32'd0);
    check("reset/color", 32'(color), 32'd0);
    reset = 1'b0;

    run_cmd("full", 8'd0, 8'd0, 8'(PW), 8'(PH), '0, 0);
    run_cmd("clip", 8'd60, 8'd30, 8'd10, 8'd10, CLW'(24'h123456), 0);
    run_cmd("empty_w", 8'd5, 8'd5, 8'd0, 8'd7, CLW'(24'hABCDEF), 0);
    run_cmd("empty_x", 8'(PW), 8'd3, 8'd5, 8'd5, CLW'(24'h010203), 0);
    run_cmd("empty_y", 8'd0, 8'(PH), 8'd5, 8'd5, CLW'(24'h040506), 0);
    run_cmd("edge_row", 8'd10, 8'(PH - 1), 8'd100, 8'd1, CLW'(24'h778899), 0);

    // Abort after y1; later strobes with enable low must not complete a command.
    enable = 1'b1;
    data_ready = 1'b0;
    step();
    send(8'd1, 0);
    send(8'd2, 0);
    enable = 1'b0;
    data_ready = 1'b0;
    step();
    send(8'd4, 0);
    send(8'd4, 0);
    for (int k = 0; k < BPP; k++) send(8'h33, 0);
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort/quiet", 32'({subcmd_enable, subcmd_ack, done}), 32'd0);
    end
    run_cmd("after_abort", 8'd3, 8'd4, 8'd5, 8'd6, CLW'(24'h0F0E0D), 0);

    run_cmd("gapped", 8'd60, 8'd30, 8'd10, 8'd10, CLW'(24'h123456), 4);

    // Reset while the fill is running.
    col = CLW'(24'hC0FFEE);
    enable = 1'b1;
    data_ready = 1'b1;
    data_in = 8'h5A;
    step();
    send(8'd8, 0);
    send(8'd9, 0);
    send(8'd20, 0);
    send(8'd10, 0);
    for (int k = BPP - 1; k >= 0; k--) send(col[k*8 +: 8], 0);
    data_ready = 1'b0;
    step();
    step();
    check("rst_fill/active", 32'(subcmd_enable), 32'd1);
    check("rst_fill/x1_loaded", 32'(x1), 32'd8);
    reset = 1'b1;
    enable = 1'b0;
    step();
    check("rst_fill/flags", 32'({done, subcmd_enable, subcmd_ack}), 32'd0);
    check("rst_fill/x1", 32'(x1), 32'd0);
    check("rst_fill/width", 32'(width), 32'd0);
    check("rst_fill/color", 32'(color), 32'd0);
    reset = 1'b0;
    subcmd_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_fill/stray_done", 32'({done, subcmd_enable, subcmd_ack}), 32'd0);
    end
    subcmd_done = 1'b0;
    run_cmd("after_reset", 8'd1, 8'd1, 8'd2, 8'd2, CLW'(24'h55AA55), 0);

    check("scoreboard/drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
